pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core, the generalised successor of the fixed E/M latch. It carries a valid bit, PC, an opaque payload, and destination/source register fields between any two stages. It supports hold (stall) and clear (bubble), and counts down Tnew saturating at zero. It also provides per-source hazard compare outputs that the hazard unit uses directly for forwarding and stall decisions.

---
 rtl/pipe_stage_reg.sv | 132 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/PC/payload/register fields, Tnew countdown, hazard compares.
// Latency 1 cycle on capture; en=0 holds contents (stall), clear loads a bubble and wins over en.
module pipe_stage_reg #(
  parameter int DATA_W       = 64,
  parameter int A_W          = 5,
  parameter int TNEW_W       = 4,
  parameter int N_SRC        = 2,
  parameter int CNT_W        = 8,
  parameter int DECR_ON_HOLD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [31:0]             in_pc,
  input  logic [DATA_W-1:0]       in_payload,
  input  logic                    in_reg_write,
  input  logic [A_W-1:0]          in_a3,
  input  logic [TNEW_W-1:0]       in_tnew,
  input  logic [N_SRC-1:0]        in_a_use,
  input  logic [N_SRC*A_W-1:0]    in_a,
  output logic                    out_valid,
  output logic [31:0]             out_pc,
  output logic [DATA_W-1:0]       out_payload,
  output logic                    out_reg_write,
  output logic [A_W-1:0]          out_a3,
  output logic [TNEW_W-1:0]       out_tnew,
  output logic [N_SRC-1:0]        out_a_use,
  output logic [N_SRC*A_W-1:0]    out_a,
  input  logic [N_SRC*A_W-1:0]    cons_a,
  input  logic [N_SRC*TNEW_W-1:0] cons_tuse,
  output logic [N_SRC-1:0]        match,
  output logic [N_SRC-1:0]        fwd_ok,
  output logic [N_SRC-1:0]        stall_req,
  output logic [CNT_W-1:0]        hold_cnt
);

  logic                 valid_q, valid_d;
  logic [31:0]          pc_q, pc_d;
  logic [DATA_W-1:0]    payload_q, payload_d;
  logic                 reg_write_q, reg_write_d;
  logic [A_W-1:0]       a3_q, a3_d;
  logic [TNEW_W-1:0]    tnew_q, tnew_d;
  logic [N_SRC-1:0]     a_use_q, a_use_d;
  logic [N_SRC*A_W-1:0] a_q, a_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    payload_d   = payload_q;
    reg_write_d = reg_write_q;
    a3_d        = a3_q;
    tnew_d      = tnew_q;
    a_use_d     = a_use_q;
    a_d         = a_q;
    hold_cnt_d  = hold_cnt_q;
    if (clear) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      payload_d   = '0;
      reg_write_d = 1'b0;
      a3_d        = '0;
      tnew_d      = '0;
      a_use_d     = '0;
      a_d         = '0;
      hold_cnt_d  = '0;
    end else if (en) begin
      valid_d     = in_valid;
      pc_d        = in_pc;
      payload_d   = in_payload;
      // A bubble entering the stage must never look like a writer or reader.
      reg_write_d = in_reg_write & in_valid;
      a3_d        = in_a3;
      tnew_d      = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
      a_use_d     = in_valid ? in_a_use : '0;
      a_d         = in_a;
      hold_cnt_d  = '0;
    end else begin
      if (DECR_ON_HOLD != 0 && tnew_q != '0) tnew_d = tnew_q - 1'b1;
      if (valid_q && !(&hold_cnt_q)) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      payload_q   <= '0;
      reg_write_q <= 1'b0;
      a3_q        <= '0;
      tnew_q      <= '0;
      a_use_q     <= '0;
      a_q         <= '0;
      hold_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      payload_q   <= payload_d;
      reg_write_q <= reg_write_d;
      a3_q        <= a3_d;
      tnew_q      <= tnew_d;
      a_use_q     <= a_use_d;
      a_q         <= a_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Register $0 is hardwired, so a writer to it never creates a hazard.
  always_comb begin
    match     = '0;
    fwd_ok    = '0;
    stall_req = '0;
    for (int i = 0; i < N_SRC; i++) begin
      match[i]     = valid_q & reg_write_q & (a3_q != '0) & (a3_q == cons_a[i*A_W +: A_W]);
      fwd_ok[i]    = match[i] & (tnew_q == '0);
      stall_req[i] = match[i] & (tnew_q > cons_tuse[i*TNEW_W +: TNEW_W]);
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_payload   = payload_q;
  assign out_reg_write = reg_write_q;
  assign out_a3        = a3_q;
  assign out_tnew      = tnew_q;
  assign out_a_use     = a_use_q;
  assign out_a         = a_q;
  assign hold_cnt      = hold_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (DECR_ON_HOLD=0 and 1) against a behavioural model.
module tb_pipe_stage_reg;

  logic        clk, reset, en, clear, in_valid, in_reg_write;
  logic [31:0] in_pc;
  logic [63:0] in_payload;
  logic [4:0]  in_a3;
  logic [3:0]  in_tnew;
  logic [1:0]  in_a_use;
  logic [9:0]  in_a, cons_a;
  logic [7:0]  cons_tuse;

  logic [1:0]  o_valid, o_rw;
  logic [31:0] o_pc [2];
  logic [63:0] o_payload [2];
  logic [4:0]  o_a3 [2];
  logic [3:0]  o_tnew [2];
  logic [1:0]  o_a_use [2], o_match [2], o_fwd [2], o_stall [2];
  logic [9:0]  o_a [2];
  logic [7:0]  o_hold [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.DECR_ON_HOLD(g)) u_dut (
      .clk(clk), .reset(reset), .en(en), .clear(clear),
      .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
      .in_reg_write(in_reg_write), .in_a3(in_a3), .in_tnew(in_tnew),
      .in_a_use(in_a_use), .in_a(in_a),
      .out_valid(o_valid[g]), .out_pc(o_pc[g]), .out_payload(o_payload[g]),
      .out_reg_write(o_rw[g]), .out_a3(o_a3[g]), .out_tnew(o_tnew[g]),
      .out_a_use(o_a_use[g]), .out_a(o_a[g]),
      .cons_a(cons_a), .cons_tuse(cons_tuse),
      .match(o_match[g]), .fwd_ok(o_fwd[g]), .stall_req(o_stall[g]),
      .hold_cnt(o_hold[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what each stage slot must contain, in plain integers.
  typedef struct {
    bit          valid;
    bit [31:0]   pc;
    bit [63:0]   payload;
    bit          rw;
    int          a3;
    int          tnew;
    bit [1:0]    a_use;
    bit [9:0]    a;
    int          hold;
  } slot_t;
  slot_t m [2];

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset || clear) begin
        m[k] = '{default: 0};
      end else if (en) begin
        m[k].valid   = in_valid;
        m[k].pc      = in_pc;
        m[k].payload = in_payload;
        m[k].rw      = in_valid && in_reg_write;
        m[k].a3      = int'(in_a3);
        m[k].tnew    = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
        m[k].a_use   = in_valid ? in_a_use : 2'b00;
        m[k].a       = in_a;
        m[k].hold    = 0;
      end else begin
        if (k == 1 && m[k].tnew > 0) m[k].tnew = m[k].tnew - 1;
        if (m[k].valid && m[k].hold < 255) m[k].hold = m[k].hold + 1;
      end
    end
  end

  function automatic bit [5:0] exp_haz(int k);
    bit [1:0] mt, fw, st;
    mt = 0; fw = 0; st = 0;
    for (int i = 0; i < 2; i++) begin
      int ca, tu;
      ca = int'(cons_a[i*5 +: 5]);
      tu = int'(cons_tuse[i*4 +: 4]);
      mt[i] = m[k].valid && m[k].rw && m[k].a3 != 0 && m[k].a3 == ca;
      fw[i] = mt[i] && m[k].tnew == 0;
      st[i] = mt[i] && m[k].tnew > tu;
    end
    return {st, fw, mt};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("valid%0d", k),   64'(o_valid[k]),   64'(m[k].valid));
        check($sformatf("pc%0d", k),      64'(o_pc[k]),      64'(m[k].pc));
        check($sformatf("payload%0d", k), o_payload[k],      m[k].payload);
        check($sformatf("rw%0d", k),      64'(o_rw[k]),      64'(m[k].rw));
        check($sformatf("a3_%0d", k),     64'(o_a3[k]),      64'(m[k].a3));
        check($sformatf("tnew%0d", k),    64'(o_tnew[k]),    64'(m[k].tnew));
        check($sformatf("a_use%0d", k),   64'(o_a_use[k]),   64'(m[k].a_use));
        check($sformatf("a%0d", k),       64'(o_a[k]),       64'(m[k].a));
        check($sformatf("hold%0d", k),    64'(o_hold[k]),    64'(m[k].hold));
        check($sformatf("haz%0d", k),     64'({o_stall[k], o_fwd[k], o_match[k]}), 64'(exp_haz(k)));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(bit v, logic [31:0] pc, bit rw, logic [4:0] a3, logic [3:0] tn);
    en = 1'b1; clear = 1'b0; in_valid = v; in_pc = pc; in_reg_write = rw;
    in_a3 = a3; in_tnew = tn;
    in_payload = {pc, ~pc};
  endtask

  initial begin
    en = 0; clear = 0; in_valid = 0; in_pc = 0; in_payload = 0; in_reg_write = 0;
    in_a3 = 0; in_tnew = 0; in_a_use = 0; in_a = 0; cons_a = 0; cons_tuse = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_valid", 64'(o_valid[0]), 64'd0);
    check("rst_pc",    64'(o_pc[1]),    64'd0);
    check("rst_hold",  64'(o_hold[0]),  64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Capture, then hold three cycles.
    load(1, 32'h3000, 1, 5'd5, 4'd2);
    in_a_use = 2'b11; in_a = {5'd3, 5'd2};
    tick();
    check("cap_pc",   64'(o_pc[0]),   64'h3000);
    check("cap_tnew", 64'(o_tnew[0]), 64'd1);
    en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("hold_cnt_%0d", c), 64'(o_hold[0]), 64'(c));
      check("hold_tnew0", 64'(o_tnew[0]), 64'd1);
      check("hold_tnew1", 64'(o_tnew[1]), 64'd0);
      check("hold_a3",    64'(o_a3[0]),   64'd5);
    end

    // Tnew countdown on successive captures: 2,1,0 -> 1,0,0.
    load(1, 32'h3004, 1, 5'd5, 4'd1);
    tick();
    check("recap_hold", 64'(o_hold[0]), 64'd0);
    check("cnt_tnew1",  64'(o_tnew[0]), 64'd0);
    in_tnew = 4'd0;
    tick();
    check("cnt_tnew0",  64'(o_tnew[0]), 64'd0);

    // Clear wins over en.
    load(1, 32'h3008, 1, 5'd7, 4'd3);
    clear = 1'b1; cons_a = {5'd7, 5'd7};
    tick();
    check("clr_valid", 64'(o_valid[0]), 64'd0);
    check("clr_a3",    64'(o_a3[0]),    64'd0);
    check("clr_match", 64'(o_match[0]), 64'd0);

    // Hazard compare: producer a3=8, Tnew 1 after capture.
    load(1, 32'h300c, 1, 5'd8, 4'd2);
    cons_a = {5'd9, 5'd8}; cons_tuse = 8'h00;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hz_match%0d", k), 64'(o_match[k]), 64'b01);
      check($sformatf("hz_stall%0d", k), 64'(o_stall[k]), 64'b01);
      check($sformatf("hz_fwd%0d", k),   64'(o_fwd[k]),   64'b00);
    end
    en = 1'b0;
    tick();
    check("hz_fwd_decr",   64'(o_fwd[1]),   64'b01);
    check("hz_stall_decr", 64'(o_stall[1]), 64'b00);
    check("hz_stall_keep", 64'(o_stall[0]), 64'b01);
    cons_tuse = {4'd0, 4'd1};
    tick();
    check("hz_tuse_ok", 64'(o_stall[0]), 64'b00);

    // $0 destination never matches; invalid capture drops writes and uses.
    load(1, 32'h3010, 1, 5'd0, 4'd0);
    cons_a = 10'd0;
    tick();
    check("zero_match", 64'(o_match[0]), 64'd0);
    load(0, 32'h3014, 1, 5'd4, 4'd0);
    in_a_use = 2'b11; cons_a = {5'd4, 5'd4};
    tick();
    check("inv_rw",    64'(o_rw[0]),    64'd0);
    check("inv_a_use", 64'(o_a_use[0]), 64'd0);
    check("inv_match", 64'(o_match[0]), 64'd0);
    en = 1'b0;
    tick(2);
    check("inv_hold", 64'(o_hold[0]), 64'd0);

    // Hold counter saturation.
    load(1, 32'h3018, 1, 5'd6, 4'd0);
    tick();
    en = 1'b0;
    tick(260);
    check("sat_hold", 64'(o_hold[0]), 64'd255);
    load(1, 32'h301c, 1, 5'd6, 4'd0);
    tick();
    check("sat_recap", 64'(o_hold[0]), 64'd0);

    // Reset asserted between edges takes effect immediately.
    load(1, 32'h3004, 1, 5'd5, 4'd2);
    cons_a = {5'd5, 5'd5};
    tick();
    en = 1'b0;
    tick();
    check("pre_rst_match", 64'(o_match[0]), 64'b11);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pc",    64'(o_pc[0]),    64'd0);
    check("mid_rst_valid", 64'(o_valid[1]), 64'd0);
    check("mid_rst_match", 64'(o_match[0]), 64'd0);
    check("mid_rst_hold",  64'(o_hold[0]),  64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    load(1, 32'h4000, 1, 5'd9, 4'd3);
    tick();
    check("post_rst_pc",   64'(o_pc[0]),   64'h4000);
    check("post_rst_tnew", 64'(o_tnew[1]), 64'd2);
    en = 1'b0;
    tick(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
